// File: rtl/gctr_counter_gen.sv
// AES-GCM counter-block sequencer: issues J0 once, then N incremented counter blocks
// over a valid/ready handshake. Every output comes straight from a flop.
module gctr_counter_gen #(
  parameter int unsigned NB_BLOCK = 128,
  parameter int unsigned NB_IV    = 96,
  parameter int unsigned NB_MODE  = 2,
  parameter int unsigned NB_LEN   = 16
) (
  input  logic                i_clock,
  input  logic                i_async_reset_n,
  input  logic                i_start,
  input  logic [NB_IV-1:0]    i_iv,
  input  logic                i_j0_sel,
  input  logic [NB_BLOCK-1:0] i_j0,
  input  logic [NB_LEN-1:0]   i_n_blocks,
  input  logic [NB_MODE-1:0]  i_rf_static_mode,
  input  logic                i_ready,
  output logic [NB_BLOCK-1:0] o_block,
  output logic                o_valid,
  output logic                o_is_j0,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {StIdle, StSendJ0, StSendCtr, StDone} state_e;

  state_e              state_q, state_d;
  logic [NB_BLOCK-1:0] ctr_q, ctr_d;
  logic [NB_LEN-1:0]   rem_q, rem_d;
  logic                inc64_q, inc64_d;
  logic                valid_q, valid_d;
  logic                is_j0_q, is_j0_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                xfer;
  logic [NB_BLOCK-1:0] ctr_inc;

  assign xfer = valid_q & i_ready;

  // Carry never leaves the selected low field: bits above it are passed through untouched.
  always_comb begin
    ctr_inc = ctr_q;
    if (inc64_q) begin
      ctr_inc[63:0] = ctr_q[63:0] + 64'd1;
    end else begin
      ctr_inc[31:0] = ctr_q[31:0] + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    inc64_d = inc64_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          ctr_d   = i_j0_sel ? i_j0 : {i_iv, 31'b0, 1'b1};
          rem_d   = i_n_blocks;
          inc64_d = (i_rf_static_mode != '0);
          state_d = StSendJ0;
        end
      end
      StSendJ0: begin
        if (xfer) begin
          if (rem_q == '0) begin
            state_d = StDone;
          end else begin
            ctr_d   = ctr_inc;
            state_d = StSendCtr;
          end
        end
      end
      StSendCtr: begin
        if (xfer) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == NB_LEN'(1)) begin
            state_d = StDone;
          end else begin
            ctr_d = ctr_inc;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Output flags are precomputed from the next state so they leave the block registered.
    valid_d = (state_d == StSendJ0) || (state_d == StSendCtr);
    is_j0_d = (state_d == StSendJ0);
    last_d  = ((state_d == StSendJ0) && (rem_d == '0)) ||
              ((state_d == StSendCtr) && (rem_d == NB_LEN'(1)));
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge i_clock or negedge i_async_reset_n) begin
    if (!i_async_reset_n) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      rem_q   <= '0;
      inc64_q <= 1'b0;
      valid_q <= 1'b0;
      is_j0_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      inc64_q <= inc64_d;
      valid_q <= valid_d;
      is_j0_q <= is_j0_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_block = ctr_q;
  assign o_valid = valid_q;
  assign o_is_j0 = is_j0_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_gctr_counter_gen.sv
// Bench for gctr_counter_gen: directed and random messages against an arithmetic model of
// the expected counter sequence, with random backpressure, ignored starts and a reset abort.
module tb_gctr_counter_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [95:0]  i_iv = '0;
  logic         i_j0_sel = 1'b0;
  logic [127:0] i_j0 = '0;
  logic [15:0]  i_n_blocks = '0;
  logic [1:0]   i_rf_static_mode = '0;
  logic         i_ready = 1'b0;
  logic [127:0] o_block;
  logic         o_valid, o_is_j0, o_last, o_busy, o_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gctr_counter_gen dut (
    .i_clock          (clk),
    .i_async_reset_n  (rst_n),
    .i_start          (i_start),
    .i_iv             (i_iv),
    .i_j0_sel         (i_j0_sel),
    .i_j0             (i_j0),
    .i_n_blocks       (i_n_blocks),
    .i_rf_static_mode (i_rf_static_mode),
    .i_ready          (i_ready),
    .o_block          (o_block),
    .o_valid          (o_valid),
    .o_is_j0          (o_is_j0),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Block k of a message is J0 plus k in the low 32 or 64 bits, modulo that field width.
  function automatic logic [127:0] model_block(input logic [127:0] j0, input int k,
                                               input logic inc64);
    logic [127:0] r;
    r = j0;
    if (inc64) r[63:0] = j0[63:0] + 64'(k);
    else       r[31:0] = j0[31:0] + 32'(k);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered and left at a negedge. Ready for cycle c comes from rpat[c] while c < rpat_len,
  // afterwards random or held high.
  task automatic run_msg(input logic [95:0] iv, input logic sel, input logic [127:0] j0,
                         input int n, input logic [1:0] mode, input logic [31:0] rpat,
                         input int rpat_len, input logic rand_rdy);
    logic [127:0] exp_j0;
    logic [127:0] exp_q[$];
    logic         inc64;
    logic         rdy;
    int           idx;
    int           c;
    int           budget;
    exp_j0 = sel ? j0 : {iv, 32'h0000_0001};
    inc64  = (mode != 2'd0);
    exp_q.delete();
    for (int k = 0; k <= n; k++) exp_q.push_back(model_block(exp_j0, k, inc64));

    i_iv = iv; i_j0_sel = sel; i_j0 = j0; i_n_blocks = 16'(n); i_rf_static_mode = mode;
    i_start = 1'b1;
    i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble every message input: the DUT must have latched them already.
    i_start = 1'b0;
    i_iv = {$urandom, $urandom, $urandom};
    i_j0 = rand128();
    i_j0_sel = 1'($urandom);
    i_n_blocks = 16'($urandom);
    i_rf_static_mode = 2'($urandom);

    idx = 0;
    c = 0;
    budget = 20 * (n + 2);
    while (idx <= n && c < budget) begin
      check("valid", o_valid, 1'b1);
      check("block", o_block, exp_q[idx]);
      check("is_j0", o_is_j0, idx == 0);
      check("last", o_last, idx == n);
      check("busy", o_busy, 1'b1);
      check("done_early", o_done, 1'b0);
      if (c < rpat_len) rdy = rpat[c];
      else              rdy = rand_rdy ? 1'($urandom) : 1'b1;
      i_ready = rdy;
      i_start = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      @(negedge clk);
      if (rdy) idx++;
      c++;
    end
    check("timeout", c < budget, 1'b1);
    i_start = 1'($urandom);
    i_ready = 1'($urandom);
    check("done_valid", o_valid, 1'b0);
    check("done", o_done, 1'b1);
    check("done_busy", o_busy, 1'b1);
    @(negedge clk);
    i_start = 1'b0;
    check("idle_valid", o_valid, 1'b0);
    check("idle_done", o_done, 1'b0);
    check("idle_busy", o_busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_block"}, o_block, '0);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_is_j0"}, o_is_j0, 1'b0);
    check({tag, "_last"}, o_last, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
  endtask

  initial begin
    logic [127:0] rj0;
    logic [127:0] abort_j0;

    // Step 1: reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Step 2: basic inc32, ready always high.
    run_msg(96'hCAFEBABEFACEDBADDECAF888, 1'b0, '0, 3, 2'd0, 32'h0, 0, 1'b0);

    // Step 3: same stimulus with ready pattern 1,0,0,1,0,1,1.
    run_msg(96'hCAFEBABEFACEDBADDECAF888, 1'b0, '0, 3, 2'd0, 32'h69, 7, 1'b0);

    // Step 4: inc32 wrap leaves bit 32 alone.
    run_msg('0, 1'b1, 128'h0123456789ABCDEF00000000_FFFFFFFE, 2, 2'd0, 32'h0, 0, 1'b0);

    // Step 5: inc64 wrap; mode is scrambled after start inside run_msg.
    run_msg('0, 1'b1, 128'hAAAAAAAAAAAAAAAA_FFFFFFFFFFFFFFFF, 1, 2'd1, 32'h0, 0, 1'b0);

    // Step 6: N = 0, J0 is both first and last.
    run_msg(96'h123456789ABCDEF012345678, 1'b0, '0, 0, 2'd2, 32'h0, 0, 1'b0);

    // Step 7: random messages with random backpressure, near-wrap J0 values.
    for (int m = 0; m < 24; m++) begin
      rj0 = rand128();
      if ($urandom_range(0, 1) == 1) rj0[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) rj0[63:0] = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      run_msg({$urandom, $urandom, $urandom}, 1'($urandom), rj0, $urandom_range(0, 6),
              2'($urandom), 32'h0, 0, 1'b1);
    end

    // Step 8: abort mid-message with ready low, then a fresh message.
    abort_j0 = 128'h11112222333344445555666677778888;
    i_j0_sel = 1'b1; i_j0 = abort_j0; i_n_blocks = 16'd5; i_rf_static_mode = 2'd0;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    i_ready = 1'b0;
    i_start = 1'b1;
    check("abort_pre_block", o_block, model_block(abort_j0, 2, 1'b0));
    check("abort_pre_valid", o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    i_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_abort");
    run_msg(96'h0F0E0D0C0B0A090807060504, 1'b0, '0, 2, 2'd3, 32'h0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
